traffic_phase_scheduler: RTL and testbench

//  Demand-driven sequencer for the four-approach junction (RS, RD, RT, LD).

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/rr_arbiter4.sv | 21 ++
 rtl/traffic_phase_scheduler.sv | 131 +++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes, approach indices, FSM states and the light-head decode for the junction sequencer.
// Pure definitions: no latency, no flow control.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    localparam logic [1:0] AP_RS = 2'd0;
    localparam logic [1:0] AP_RD = 2'd1;
    localparam logic [1:0] AP_RT = 2'd2;
    localparam logic [1:0] AP_LD = 2'd3;

    typedef enum logic [2:0] {
        ALLRED   = 3'd0,
        GREEN    = 3'd1,
        YELLOW   = 3'd2,
        EMG_HOLD = 3'd3
    } phase_state_e;

    // Heads packed as {LD, RT, RD, RS}; only the granted approach may leave red.
    function automatic logic [11:0] light_decode(input phase_state_e st, input logic [1:0] ph);
        logic [11:0] l;
        l = {4{LT_RED}};
        case (st)
            GREEN, EMG_HOLD: l[3*int'(ph) +: 3] = LT_GRN;
            YELLOW:          l[3*int'(ph) +: 3] = LT_YEL;
            default:         l = {4{LT_RED}};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Rotate-priority pick among four requesters, searching last+1, +2, +3, +0; falls back to last+1 when idle.
// Purely combinational, zero latency; no backpressure.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant_idx,
    output logic       any
);

    always_comb begin
        grant_idx = last + 2'd1;
        any       = |req;
        // Walk from the farthest candidate back so the nearest requester wins.
        for (int k = 4; k >= 1; k--) begin
            if (req[2'(last + 2'(k))]) begin
                grant_idx = 2'(last + 2'(k));
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven junction sequencer: round-robin green with min/max green, yellow, all-red and emergency hold.
// Lights are registered and change on the edge entering a state; inputs are levels, no backpressure.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 1,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       emg_valid,
    input  logic [1:0] emg_dir,
    output logic       emg_ack,
    output logic [2:0] light_RS,
    output logic [2:0] light_RD,
    output logic [2:0] light_RT,
    output logic [2:0] light_LD,
    output logic [1:0] active_phase,
    output logic [2:0] phase_state
);

    localparam int TW = 16;
    // Each bound is the timer value on a state's final cycle, so a D-tick state spans D*TICK_DIV cycles.
    localparam logic [TW-1:0] G_MIN_LAST = TW'(GREEN_MIN * TICK_DIV - 1);
    localparam logic [TW-1:0] G_MAX_LAST = TW'(GREEN_MAX * TICK_DIV - 1);
    localparam logic [TW-1:0] Y_LAST     = TW'(YELLOW_T * TICK_DIV - 1);
    localparam logic [TW-1:0] AR_LAST    = TW'(ALLRED_T * TICK_DIV - 1);

    phase_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    phase_q, phase_d;
    logic [11:0]   lights_q, lights_d;
    logic          emg_ack_q, emg_ack_d;
    logic [1:0]    rr_grant;
    logic          rr_any;
    logic          competing;

    rr_arbiter4 u_rr (
        .req       (req),
        .last      (phase_q),
        .grant_idx (rr_grant),
        .any       (rr_any)
    );

    assign competing = |(req & ~(4'b0001 << phase_q));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            GREEN: begin
                // Max-green expiry takes precedence over a same-approach emergency.
                if (timer_q == G_MAX_LAST) begin
                    state_d = YELLOW;
                end else if (emg_valid) begin
                    if (emg_dir == phase_q) begin
                        state_d = EMG_HOLD;
                    end else begin
                        state_d = YELLOW;
                    end
                end else if ((timer_q >= G_MIN_LAST) && competing) begin
                    state_d = YELLOW;
                end
            end
            YELLOW: begin
                if (timer_q == Y_LAST) begin
                    state_d = ALLRED;
                end
            end
            ALLRED: begin
                if (timer_q == AR_LAST) begin
                    if (emg_valid) begin
                        state_d = EMG_HOLD;
                        phase_d = emg_dir;
                    end else begin
                        state_d = GREEN;
                        phase_d = rr_any ? rr_grant : phase_q + 2'd1;
                    end
                end
            end
            EMG_HOLD: begin
                if (!emg_valid) begin
                    state_d = YELLOW;
                end
            end
            default: begin
                state_d = ALLRED;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == {TW{1'b1}}) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        lights_d  = light_decode(state_d, phase_d);
        emg_ack_d = (state_d == EMG_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ALLRED;
            timer_q   <= '0;
            phase_q   <= AP_LD;
            lights_q  <= {4{LT_RED}};
            emg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            phase_q   <= phase_d;
            lights_q  <= lights_d;
            emg_ack_q <= emg_ack_d;
        end
    end

    assign light_RS     = lights_q[2:0];
    assign light_RD     = lights_q[5:3];
    assign light_RT     = lights_q[8:6];
    assign light_LD     = lights_q[11:9];
    assign active_phase = phase_q;
    assign phase_state  = state_q;
    assign emg_ack      = emg_ack_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: expected light segments queued per scenario, compared as lights change.
// Every observed segment is also checked against the clearance and green-duration rules.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       emg_valid = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic       emg_ack;
    logic [2:0] light_RS, light_RD, light_RT, light_LD;
    logic [1:0] active_phase;
    logic [2:0] phase_state;
    logic [11:0] lights;

    traffic_phase_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .emg_valid    (emg_valid),
        .emg_dir      (emg_dir),
        .emg_ack      (emg_ack),
        .light_RS     (light_RS),
        .light_RD     (light_RD),
        .light_RT     (light_RT),
        .light_LD     (light_LD),
        .active_phase (active_phase),
        .phase_state  (phase_state)
    );

    assign lights = {light_LD, light_RT, light_RD, light_RS};

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] val;
        int          len;
    } seg_t;

    seg_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] mk(input int ph, input logic [2:0] code);
        logic [11:0] v;
        v = ALL_RED;
        v[ph*3 +: 3] = code;
        return v;
    endfunction

    function automatic int head_of(input logic [11:0] v);
        int h;
        h = -1;
        for (int i = 0; i < 4; i++) if (v[i*3 +: 3] != LT_RED) h = i;
        return h;
    endfunction

    function automatic int nonred_cnt(input logic [11:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (v[i*3 +: 3] != LT_RED) n++;
        return n;
    endfunction

    function automatic bit heads_onehot(input logic [11:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (!$onehot(v[i*3 +: 3])) ok = 1'b0;
        return ok;
    endfunction

    task automatic push(input logic [11:0] v, input int len);
        seg_t s;
        s.val = v;
        s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic seg_rules(input logic [11:0] v, input int len, input bit pre, input logic [11:0] nxt);
        int h;
        int nh;
        logic [2:0] nslot;
        h = head_of(v);
        if (h < 0) begin
            nh = head_of(nxt);
            nslot = (nh >= 0) ? nxt[nh*3 +: 3] : 3'b000;
            check_eq("allred_len", len, 1);
            check_eq("allred_to_green", nslot, LT_GRN);
        end else if (v[h*3 +: 3] == LT_YEL) begin
            check_eq("yellow_len", len, 3);
            check_eq("yellow_to_allred", nxt, ALL_RED);
        end else begin
            check_eq("green_to_yellow", nxt, mk(h, LT_YEL));
            if (!pre) begin
                check_eq("green_min", len >= 5, 1);
                check_eq("green_max", len <= 15, 1);
            end
        end
    endtask

    // Segment monitor: a segment is a run of identical light vectors; reset discards the run in progress.
    initial begin : mon
        logic [11:0] cur_val;
        int          cur_len;
        bit          cur_pre;
        int          h;
        seg_t        e;
        cur_val = ALL_RED;
        cur_len = 0;
        cur_pre = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_val = lights;
                cur_len = 0;
                cur_pre = 1'b0;
            end else begin
                check_eq("heads_onehot", heads_onehot(lights), 1);
                check_eq("nonred_le1", nonred_cnt(lights) <= 1, 1);
                h = head_of(lights);
                if (h >= 0) check_eq("head_is_active", h, active_phase);
                check_eq("ack_vs_state", emg_ack, phase_state == 3'd3);
                if (lights == cur_val) begin
                    cur_len++;
                end else begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("seg_val(exp %03h)", e.val), cur_val, e.val);
                        check_eq($sformatf("seg_len(%03h)", e.val), cur_len, e.len);
                    end
                    seg_rules(cur_val, cur_len, cur_pre, lights);
                    cur_val = lights;
                    cur_len = 1;
                    cur_pre = 1'b0;
                end
                if (emg_valid || emg_ack) cur_pre = 1'b1;
            end
        end
    end

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_rst_lights"}, lights, ALL_RED);
        check_eq({tag, "_rst_ack"}, emg_ack, 0);
        check_eq({tag, "_rst_phase"}, active_phase, 3);
        check_eq({tag, "_rst_state"}, phase_state, 0);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        check_eq({tag, "_pending_segments"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (!emg_ack && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, emg_ack, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int emg_left;

        // Idle demand: fixed-cycle fallback RS, RD, RT, LD, RS.
        push(ALL_RED, 1);
        for (int p = 0; p < 4; p++) begin
            push(mk(p, LT_GRN), 15);
            push(mk(p, LT_YEL), 3);
            push(ALL_RED, 1);
        end
        push(mk(0, LT_GRN), 15);
        do_reset("s1");
        drain("s1", 200);

        // Competing LD demand cuts RS at min green; RD/RT skipped.
        push(ALL_RED, 1);
        push(mk(0, LT_GRN), 5);
        push(mk(0, LT_YEL), 3);
        push(ALL_RED, 1);
        push(mk(3, LT_GRN), 15);
        do_reset("s2");
        @(posedge clk);
        #1;
        req = 4'b1000;
        drain("s2", 100);
        req = 4'b0000;

        // Emergency to RT while RS is at timer 2.
        push(ALL_RED, 1);
        push(mk(0, LT_GRN), 3);
        push(mk(0, LT_YEL), 3);
        push(ALL_RED, 1);
        push(mk(2, LT_GRN), 21);
        push(mk(2, LT_YEL), 3);
        push(ALL_RED, 1);
        push(mk(3, LT_GRN), 15);
        do_reset("s3");
        repeat (3) @(posedge clk);
        #1;
        emg_valid = 1'b1;
        emg_dir   = 2'd2;
        wait_ack("s3_ack_high");
        check_eq("s3_hold_phase", active_phase, 2);
        check_eq("s3_hold_lights", lights, mk(2, LT_GRN));
        repeat (20) @(posedge clk);
        #1;
        emg_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("s3_ack_low", emg_ack, 0);
        check_eq("s3_state_yellow", phase_state, 2);
        drain("s3", 100);

        // Emergency on the approach already green: hold past max green without a light change.
        push(ALL_RED, 1);
        push(mk(0, LT_GRN), 34);
        push(mk(0, LT_YEL), 3);
        push(ALL_RED, 1);
        push(mk(1, LT_GRN), 15);
        do_reset("s4");
        repeat (3) @(posedge clk);
        #1;
        emg_valid = 1'b1;
        emg_dir   = 2'd0;
        wait_ack("s4_ack_high");
        check_eq("s4_state_hold", phase_state, 3);
        repeat (20) @(posedge clk);
        #1;
        check_eq("s4_green_past_max", lights, mk(0, LT_GRN));
        repeat (10) @(posedge clk);
        #1;
        emg_valid = 1'b0;
        drain("s4", 100);

        // Reset asserted mid-yellow clears asynchronously; RS served first afterwards.
        push(ALL_RED, 1);
        push(mk(0, LT_GRN), 15);
        do_reset("s5a");
        repeat (17) @(posedge clk);
        #1;
        check_eq("s5_mid_yellow", lights, mk(0, LT_YEL));
        rst = 1'b1;
        #1;
        check_eq("s5_async_lights", lights, ALL_RED);
        check_eq("s5_async_state", phase_state, 0);
        check_eq("s5_async_phase", active_phase, 3);
        push(ALL_RED, 1);
        push(mk(0, LT_GRN), 15);
        do_reset("s5b");
        drain("s5", 100);

        // Random demand and emergencies; the monitor applies the segment rules throughout.
        do_reset("s6");
        emg_left = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
            if (emg_left > 0) begin
                emg_left--;
                if (emg_left == 0) emg_valid = 1'b0;
                else if ($urandom_range(0, 30) == 0) emg_dir = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 150) == 0) begin
                emg_valid = 1'b1;
                emg_dir   = 2'($urandom_range(0, 3));
                emg_left  = $urandom_range(1, 40);
            end
        end
        emg_valid = 1'b0;
        req       = 4'b0000;
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
